krnl_dist_rd_mst: RTL and testbench
===================================

Name: krnl_dist_rd_mst

Overview:
AXI4 read master that fetches a contiguous block of 512-bit beats (point/centroid vectors) from global memory over an m_axi_gmem_* read channel. It delivers the beats, in order, as an AXI4-Stream to the distance datapath inside the kernel. One instance sits directly upstream of each distance compute stage, driven by start/address/length from the control register block. It issues bursts that never cross 4 KB and reserves buffer space before issuing, so RREADY never throttles memory.

Parameters:
C_ADDR_WIDTH, 64, AXI address width
C_DATA_WIDTH, 512, AXI/stream data width (bytes per beat = C_DATA_WIDTH/8)
C_LEN_WIDTH, 32, width of transfer length in beats
C_MAX_BURST, 64, max beats per AR burst (power of 2, ≤256)
C_MAX_OUTSTANDING, 4, max AR bursts in flight
C_FIFO_DEPTH, 256, data FIFO entries; must be ≥ C_MAX_OUTSTANDING*C_MAX_BURST

Ports:
ap_clk  in  1  kernel clock
ap_rst  in  1  synchronous active-high reset
ctrl_start  in  1  single-cycle start pulse
ctrl_addr  in  C_ADDR_WIDTH  byte base address; low log2(C_DATA_WIDTH/8) bits ignored (treated as 0)
ctrl_beats  in  C_LEN_WIDTH  transfer length in beats
ctrl_busy  out  1  high from accepted start until done
ctrl_done  out  1  one-cycle pulse when the transfer completes
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_araddr  out  C_ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axi_rdata  in  C_DATA_WIDTH  R data
m_axi_rlast  in  1  R last
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  C_DATA_WIDTH  stream data
m_axis_tlast  out  1  final beat of transfer

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst is synchronous and active-high.
- Reset values: every output is 0. FIFO is emptied; burst, credit and outstanding counters are cleared; FSM goes to IDLE. Reset mid-transfer aborts the transfer with no done pulse. The system resets the interconnect alongside this block.
- ARSIZE/ARBURST/cache fields: tied off by the kernel top level (full-width beats, INCR). They are not ports of this block.
- FSM states:
  - IDLE: waits for ctrl_start.
  - ISSUE: issues AR bursts until all beats are requested.
  - DRAIN: waits for every beat to leave on the stream.
  - DONE: one cycle; asserts ctrl_done, then returns to IDLE.
- IDLE transitions: start with ctrl_beats>0 goes to ISSUE; start with ctrl_beats==0 goes to DONE.
- ctrl_start while ctrl_busy is ignored.
- ctrl_busy = (state != IDLE).
- Burst length: beats = min(remaining, C_MAX_BURST, beats left to the next 4 KB boundary from the current address). arlen = beats-1.
- Address advance: araddr advances by beats*bytes_per_beat on each AR handshake. remaining decrements by beats on each AR handshake.
- Issue condition: arvalid is asserted only when outstanding < C_MAX_OUTSTANDING and free credits ≥ beats.
- Credit accounting:
  - Credits start at C_FIFO_DEPTH.
  - Credits drop by beats on the AR handshake and rise by 1 per stream handshake.
  - Simultaneous events in one cycle apply both deltas.
- AR payload: araddr and arlen are registered and stable while arvalid=1 and arready=0.
- Latency: start at cycle 0 gives arvalid=1 at cycle 1 at the earliest.
- Outstanding count: +1 on AR handshake, -1 on R handshake with rlast. When both occur in the same cycle, the count is unchanged.
- RREADY: m_axi_rready = !fifo_full. Credit reservation guarantees it is never 0 while rvalid=1. A bench assertion checks this.
- RRESP: ignored.
- Data path: R beats are written to the FIFO in arrival order (single ID, in-order). The FIFO is show-ahead: tdata is valid with tvalid.
- First-beat latency: an R beat accepted at cycle n appears on the stream at cycle n+1 or later.
- tlast: asserted on the stream beat whose running count equals ctrl_beats (latched at start). tlast is independent of rlast.
- ISSUE→DRAIN: when remaining==0 after an AR handshake.
- DRAIN→DONE: cycle after the stream handshake with tlast.
- Zero-length start: done pulse at cycle 2 after start; no AR, no stream beats.
- Counter widths: all beat counters are C_LEN_WIDTH. The address adder is C_ADDR_WIDTH and wraps silently at 2^C_ADDR_WIDTH.

Decomposition:
- Package krnl_dist_pkg holds:
  - width constants (ADDR 64, DATA 512, LEN 32)
  - BYTES_PER_BEAT and log2, and the 4 KB boundary constant
  - the FSM state enum {IDLE, ISSUE, DRAIN, DONE}
- Sub-module krnl_dist_sync_fifo: single-clock show-ahead FIFO with parameters width and depth. Ports: wr_en/din/full, rd_en/dout/empty, and a synchronous active-high reset. It is reused by the downstream writer.

Test Plan:
- Multi-burst split: base 0x0, beats 130 → ARs (0x0, arlen 63), (0x1000, 63), (0x2000, 1); 130 stream beats; tlast only on beat 130; one done pulse.
- 4 KB boundary: base 0x0FC0, beats 4 → ARs (0x0FC0, arlen 0), (0x1000, arlen 2); data order preserved; tlast on beat 4.
- Backpressure: beats 512, tready held 0 → exactly 4 ARs (256 beats reserved), then arvalid stays 0. rready stays 1 for every rvalid. Releasing tready resumes issue; all 512 beats arrive in order.
- Zero length and busy: beats 0 → ctrl_done at cycle 2, no arvalid. A second start during a 64-beat transfer is ignored: single AR, single done.
- Reset mid-transfer: assert ap_rst during the second burst → next cycle all outputs 0, busy 0, FIFO empty. A new start of 8 beats then completes normally with arlen 7.
- Random arready/rvalid/tready gaps, beats 1–1000, random aligned bases → scoreboard matches the memory model. No AR crosses 4 KB; outstanding never exceeds 4.

Source files
------------

// File: rtl/krnl_dist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : krnl_dist_pkg
// Brief    : Shared widths, beat/boundary constants and FSM state encoding
//            for the distance-kernel memory movers.
// Revision : 1.0
// ============================================================================
package krnl_dist_pkg;

    localparam int ADDR_W         = 64;
    localparam int DATA_W         = 512;
    localparam int LEN_W          = 32;
    localparam int BYTES_PER_BEAT = DATA_W / 8;
    localparam int BEAT_LOG2      = $clog2(BYTES_PER_BEAT);
    localparam int BOUNDARY_BYTES = 4096;
    localparam int BOUNDARY_LOG2  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/krnl_dist_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : krnl_dist_sync_fifo
// Brief    : Single-clock show-ahead FIFO; dout is valid whenever !empty.
// Revision : 1.0
// ============================================================================
module krnl_dist_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/krnl_dist_rd_mst.sv
`default_nettype none
// ============================================================================
// Module   : krnl_dist_rd_mst
// Brief    : AXI4 read master streaming a contiguous beat block to the
//            distance datapath, with 4 KB-safe bursts and FIFO credit checks.
// Revision : 1.0
// ============================================================================
module krnl_dist_rd_mst
    import krnl_dist_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = ADDR_W,
    parameter int C_DATA_WIDTH      = DATA_W,
    parameter int C_LEN_WIDTH       = LEN_W,
    parameter int C_MAX_BURST       = 64,
    parameter int C_MAX_OUTSTANDING = 4,
    parameter int C_FIFO_DEPTH      = 256
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [C_LEN_WIDTH-1:0]  ctrl_beats,
    output logic                    ctrl_busy,
    output logic                    ctrl_done,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                    m_axi_rlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast
);

    localparam int BPB_LOG2     = $clog2(C_DATA_WIDTH / 8);
    localparam int BEATS_PER_4K = BOUNDARY_BYTES >> BPB_LOG2;
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = ~C_ADDR_WIDTH'((1 << BPB_LOG2) - 1);

    state_e                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    arvalid_q, arvalid_d;
    logic                    done_q, done_d;
    logic [C_LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [C_LEN_WIDTH-1:0]  total_q, total_d;
    logic [C_LEN_WIDTH-1:0]  sent_q, sent_d;
    logic [C_LEN_WIDTH-1:0]  credits_q, credits_d;
    logic [C_LEN_WIDTH-1:0]  outstanding_q, outstanding_d;

    logic [C_LEN_WIDTH-1:0]  to_4k, burst;
    logic                    ar_hs, r_hs, s_hs, can_issue;
    logic                    fifo_full, fifo_empty;
    logic [C_DATA_WIDTH-1:0] fifo_dout;

    assign ctrl_busy     = (state_q != IDLE);
    assign ctrl_done     = done_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_rready  = ctrl_busy && !fifo_full;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout;
    assign m_axis_tlast  = !fifo_empty && ((sent_q + C_LEN_WIDTH'(1)) == total_q);

    assign ar_hs = arvalid_q && m_axi_arready;
    assign r_hs  = m_axi_rvalid && m_axi_rready;
    assign s_hs  = m_axis_tvalid && m_axis_tready;

    // Next burst is the smallest of what is left, the burst cap and the 4 KB page remainder.
    always_comb begin
        to_4k = C_LEN_WIDTH'(BEATS_PER_4K) - C_LEN_WIDTH'(addr_q[BOUNDARY_LOG2-1:BPB_LOG2]);
        burst = remaining_q;
        if (burst > C_LEN_WIDTH'(C_MAX_BURST)) begin
            burst = C_LEN_WIDTH'(C_MAX_BURST);
        end
        if (burst > to_4k) begin
            burst = to_4k;
        end
    end

    assign can_issue = (state_q == ISSUE) && !arvalid_q && (remaining_q != '0)
                    && (outstanding_q < C_LEN_WIDTH'(C_MAX_OUTSTANDING))
                    && (credits_q >= burst);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arvalid_d     = arvalid_q;
        done_d        = 1'b0;
        remaining_d   = remaining_q;
        total_d       = total_q;
        sent_d        = sent_q + C_LEN_WIDTH'(s_hs);
        credits_d     = credits_q + C_LEN_WIDTH'(s_hs) - (ar_hs ? burst : '0);
        outstanding_d = outstanding_q + C_LEN_WIDTH'(ar_hs)
                      - C_LEN_WIDTH'(r_hs && m_axi_rlast);

        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    addr_d      = ctrl_addr & ADDR_ALIGN_MASK;
                    remaining_d = ctrl_beats;
                    total_d     = ctrl_beats;
                    sent_d      = '0;
                    state_d     = (ctrl_beats == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    arvalid_d = 1'b1;
                    araddr_d  = addr_q;
                    arlen_d   = 8'(burst - C_LEN_WIDTH'(1));
                end
                // addr_q/remaining_q are frozen while arvalid is up, so burst still matches arlen.
                if (ar_hs) begin
                    arvalid_d   = 1'b0;
                    addr_d      = addr_q + (C_ADDR_WIDTH'(burst) << BPB_LOG2);
                    remaining_d = remaining_q - burst;
                    if (remaining_q == burst) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (s_hs && m_axis_tlast) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arvalid_q     <= 1'b0;
            done_q        <= 1'b0;
            remaining_q   <= '0;
            total_q       <= '0;
            sent_q        <= '0;
            credits_q     <= C_LEN_WIDTH'(C_FIFO_DEPTH);
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arvalid_q     <= arvalid_d;
            done_q        <= done_d;
            remaining_q   <= remaining_d;
            total_q       <= total_d;
            sent_q        <= sent_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
        end
    end

    krnl_dist_sync_fifo #(
        .WIDTH (C_DATA_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .wr_en (r_hs),
        .din   (m_axi_rdata),
        .full  (fifo_full),
        .rd_en (s_hs),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_krnl_dist_rd_mst.sv
`default_nettype none
// ============================================================================
// Module   : tb_krnl_dist_rd_mst
// Brief    : Self-checking bench: AXI memory responder, stream scoreboard,
//            table-driven transfers plus reset/backpressure/busy sequences.
// Revision : 1.0
// ============================================================================
module tb_krnl_dist_rd_mst;

    logic         ap_clk = 1'b0;
    logic         ap_rst;
    logic         ctrl_start;
    logic [63:0]  ctrl_addr;
    logic [31:0]  ctrl_beats;
    logic         ctrl_busy, ctrl_done;
    logic         m_axi_arvalid, m_axi_arready;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic         m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [511:0] m_axi_rdata;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [511:0] m_axis_tdata;

    always #5 ap_clk = ~ap_clk;

    krnl_dist_rd_mst dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ctrl_start    (ctrl_start),
        .ctrl_addr     (ctrl_addr),
        .ctrl_beats    (ctrl_beats),
        .ctrl_busy     (ctrl_busy),
        .ctrl_done     (ctrl_done),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rlast   (m_axi_rlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    typedef struct {
        logic [63:0] addr;
        int          len;
    } ar_t;

    typedef struct {
        logic [63:0] base;
        int          beats;
        int          ar_pct, r_pct, t_pct;
        int          n_ar;
        logic [63:0] a0; int l0;
        logic [63:0] a1; int l1;
        logic [63:0] a2; int l2;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           ar_pct, r_pct, t_pct;
    ar_t          ar_q[$];
    int           r_idx, outst, ar_cnt, ar_beats, s_cnt, exp_total, done_cnt;
    bit           r_fire;
    logic [63:0]  ar_log_addr[$];
    int           ar_log_len[$];
    logic [511:0] exp_q[$];
    vec_t         vecs[7];

    function automatic logic [511:0] mem_word(input logic [63:0] a);
        return {4{a, ~a}};
    endfunction

    function automatic bit rnd(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    // Memory slave and stream sink; all decisions at negedge, handshakes land on the next posedge.
    initial begin : model
        ar_t          cur;
        logic [511:0] exp_w;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rlast   = 1'b0;
        m_axis_tready = 1'b0;
        r_idx = 0; outst = 0; r_fire = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                ar_q.delete();
                r_idx = 0; outst = 0; r_fire = 1'b0;
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axis_tready = 1'b0;
            end else begin
                if (ctrl_done) done_cnt++;
                if (!(m_axi_rvalid && !r_fire)) begin
                    if (ar_q.size() > 0 && rnd(r_pct)) begin
                        cur = ar_q[0];
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = mem_word(cur.addr + (64'(r_idx) << 6));
                        m_axi_rlast  = (r_idx == cur.len);
                    end else begin
                        m_axi_rvalid = 1'b0;
                        m_axi_rlast  = 1'b0;
                    end
                end
                r_fire = m_axi_rvalid && m_axi_rready;
                if (m_axi_rvalid) chk("rready_with_rvalid", 64'(m_axi_rready), 64'd1);
                if (r_fire) begin
                    if (m_axi_rlast) begin
                        void'(ar_q.pop_front());
                        r_idx = 0;
                        outst--;
                    end else begin
                        r_idx++;
                    end
                end

                m_axi_arready = rnd(ar_pct);
                if (m_axi_arvalid && m_axi_arready) begin
                    cur.addr = m_axi_araddr;
                    cur.len  = int'(m_axi_arlen);
                    ar_q.push_back(cur);
                    ar_log_addr.push_back(m_axi_araddr);
                    ar_log_len.push_back(int'(m_axi_arlen));
                    ar_cnt++;
                    ar_beats += cur.len + 1;
                    outst++;
                    chk("ar_no_4k_cross",
                        64'(((m_axi_araddr & 64'hFFF) + ((64'(m_axi_arlen) + 64'd1) << 6)) <= 64'd4096),
                        64'd1);
                    chk("outstanding_le_4", 64'(outst <= 4), 64'd1);
                end

                m_axis_tready = rnd(t_pct);
                if (m_axis_tvalid && m_axis_tready) begin
                    s_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL stream_extra_beat: got beat %0d expected none", s_cnt);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (m_axis_tdata !== exp_w) begin
                            errors++;
                            $display("FAIL stream_data beat %0d: got %h expected %h", s_cnt, m_axis_tdata, exp_w);
                        end
                    end
                    chk("stream_tlast", 64'(m_axis_tlast), 64'(s_cnt == exp_total));
                end
            end
        end
    end

    task automatic clear_sb();
        ar_log_addr.delete();
        ar_log_len.delete();
        exp_q.delete();
        ar_cnt = 0; ar_beats = 0; s_cnt = 0; done_cnt = 0;
    endtask

    task automatic start_xfer(input logic [63:0] base, input int beats);
        logic [63:0] b;
        clear_sb();
        b = base & ~64'h3F;
        exp_total = beats;
        for (int i = 0; i < beats; i++) exp_q.push_back(mem_word(b + (64'(i) << 6)));
        ctrl_addr  = base;
        ctrl_beats = 32'(beats);
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", budget);
        end
        repeat (4) tick();
    endtask

    task automatic post_check(input int beats);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("stream_beats", 64'(s_cnt), 64'(beats));
        chk("stream_left", 64'(exp_q.size()), 64'd0);
        chk("ar_beat_sum", 64'(ar_beats), 64'(beats));
        chk("busy_after", 64'(ctrl_busy), 64'd0);
        chk("outst_after", 64'(outst), 64'd0);
    endtask

    task automatic check_ar(input int k, input logic [63:0] a, input int l);
        if (k < ar_log_addr.size()) begin
            chk("ar_addr", ar_log_addr[k], a);
            chk("ar_len", 64'(ar_log_len[k]), 64'(l));
        end else begin
            checks++;
            errors++;
            $display("FAIL ar_missing: got %0d ARs expected entry %0d", ar_log_addr.size(), k);
        end
    endtask

    initial begin : main
        logic [63:0] rb;
        int          n;
        vecs[0] = '{64'h0, 130, 100, 100, 100, 3, 64'h0, 63, 64'h1000, 63, 64'h2000, 1};
        vecs[1] = '{64'h0FC0, 4, 60, 70, 50, 2, 64'h0FC0, 0, 64'h1000, 2, 64'h0, 0};
        vecs[2] = '{64'h1F80, 70, 100, 100, 100, 3, 64'h1F80, 1, 64'h2000, 63, 64'h3000, 3};
        vecs[3] = '{64'h12345, 1, 100, 100, 100, 1, 64'h12340, 0, 64'h0, 0, 64'h0, 0};
        vecs[4] = '{64'h40, 64, 50, 50, 50, 2, 64'h40, 62, 64'h1000, 0, 64'h0, 0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC0, 2, 100, 100, 100, 2, 64'hFFFF_FFFF_FFFF_FFC0, 0, 64'h0, 0, 64'h0, 0};
        vecs[6] = '{64'h3000, 0, 100, 100, 100, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0};

        ap_rst = 1'b1; ctrl_start = 1'b0; ctrl_addr = '0; ctrl_beats = '0;
        ar_pct = 100; r_pct = 100; t_pct = 100;
        clear_sb();
        exp_total = 0;
        repeat (3) tick();
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_araddr", m_axi_araddr, 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata_zero", 64'(m_axis_tdata == '0), 64'd1);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_busy", 64'(ctrl_busy), 64'd0);
        chk("rst_done", 64'(ctrl_done), 64'd0);
        ap_rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            ar_pct = vecs[i].ar_pct; r_pct = vecs[i].r_pct; t_pct = vecs[i].t_pct;
            start_xfer(vecs[i].base, vecs[i].beats);
            wait_done(20000);
            post_check(vecs[i].beats);
            chk("ar_count", 64'(ar_cnt), 64'(vecs[i].n_ar));
            if (vecs[i].n_ar > 0) check_ar(0, vecs[i].a0, vecs[i].l0);
            if (vecs[i].n_ar > 1) check_ar(1, vecs[i].a1, vecs[i].l1);
            if (vecs[i].n_ar > 2) check_ar(2, vecs[i].a2, vecs[i].l2);
        end

        // Zero-length: done exactly two cycles after start, never an AR.
        ar_pct = 100; r_pct = 100; t_pct = 100;
        clear_sb();
        exp_total = 0;
        ctrl_addr = 64'h4000; ctrl_beats = '0; ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        chk("zl_done_c1", 64'(ctrl_done), 64'd0);
        chk("zl_busy_c1", 64'(ctrl_busy), 64'd1);
        tick();
        chk("zl_done_c2", 64'(ctrl_done), 64'd1);
        tick();
        chk("zl_done_c3", 64'(ctrl_done), 64'd0);
        repeat (3) tick();
        chk("zl_ar_count", 64'(ar_cnt), 64'd0);
        chk("zl_done_pulses", 64'(done_cnt), 64'd1);

        // Start while busy is ignored.
        start_xfer(64'h2000, 64);
        repeat (2) tick();
        chk("busy_mid", 64'(ctrl_busy), 64'd1);
        ctrl_addr = 64'h9000; ctrl_beats = 32'd10; ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        wait_done(5000);
        repeat (10) tick();
        post_check(64);
        chk("busy_ign_ar_count", 64'(ar_cnt), 64'd1);
        check_ar(0, 64'h2000, 63);

        // Stream backpressure: credits cap issue at four full bursts.
        t_pct = 0;
        start_xfer(64'h0, 512);
        repeat (300) tick();
        chk("bp_ar_count", 64'(ar_cnt), 64'd4);
        chk("bp_ar_beats", 64'(ar_beats), 64'd256);
        chk("bp_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("bp_stream_none", 64'(s_cnt), 64'd0);
        chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
        t_pct = 100;
        wait_done(20000);
        post_check(512);
        chk("bp_ar_total", 64'(ar_cnt), 64'd8);

        // Reset during the second burst aborts with no done.
        t_pct = 50;
        start_xfer(64'h0, 200);
        n = 0;
        while (ar_cnt < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("mid_reached_2nd_ar", 64'(ar_cnt >= 2), 64'd1);
        tick();
        ap_rst = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("mid_rst_araddr", m_axi_araddr, 64'd0);
        chk("mid_rst_arlen", 64'(m_axi_arlen), 64'd0);
        chk("mid_rst_rready", 64'(m_axi_rready), 64'd0);
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_tdata_zero", 64'(m_axis_tdata == '0), 64'd1);
        chk("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mid_rst_busy", 64'(ctrl_busy), 64'd0);
        chk("mid_rst_done", 64'(ctrl_done), 64'd0);
        ap_rst = 1'b0;
        repeat (5) tick();
        chk("mid_no_done", 64'(done_cnt), 64'd0);
        chk("mid_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        t_pct = 100;
        start_xfer(64'h100, 8);
        wait_done(2000);
        post_check(8);
        chk("after_rst_ar_count", 64'(ar_cnt), 64'd1);
        check_ar(0, 64'h100, 7);

        // Random gaps, lengths and aligned bases.
        for (int i = 0; i < 5; i++) begin
            rb = {32'($urandom), 32'($urandom)} & ~64'h3F;
            n  = int'($urandom_range(1000, 1));
            ar_pct = int'($urandom_range(100, 40));
            r_pct  = int'($urandom_range(100, 40));
            t_pct  = int'($urandom_range(100, 40));
            start_xfer(rb, n);
            wait_done(20000);
            post_check(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
